// File: rtl/alu_dm_grf_core_pkg.sv
// mips_pkg: shared ALU opcodes, write-back selects and data-memory geometry
// for the alu_dm_grf_core datapath slice.
`default_nettype none

package mips_pkg;

  localparam int DM_WORDS = 3072;
  localparam int DM_AW    = 12;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_MEM  = 2'd1;
  localparam logic [1:0] WD_LINK = 2'd2;

  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic zero);
    return zero ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_dm_grf_core_if.sv
// alu_dm_grf_core_if: control/data bundle between decoder, datapath slice and next-PC logic.
`default_nettype none

interface alu_dm_grf_core_if;
  logic [31:0] pc;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  wreg;
  logic [15:0] imm16;
  logic        ext_zero;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic        grf_we;
  logic        dm_we;
  logic [1:0]  wd_sel;
  logic [31:0] link_addr;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] alu_result;
  logic        equal;
  logic [31:0] wdata;

  modport master (
    output pc, rs, rt, wreg, imm16, ext_zero, alu_src, alu_op,
           grf_we, dm_we, wd_sel, link_addr,
    input  rdata1, rdata2, alu_result, equal, wdata
  );

  modport slave (
    input  pc, rs, rt, wreg, imm16, ext_zero, alu_src, alu_op,
           grf_we, dm_we, wd_sel, link_addr,
    output rdata1, rdata2, alu_result, equal, wdata
  );
endinterface

`default_nettype wire

// File: rtl/alu_dm_grf_core_grf_regs.sv
// grf_regs: 32x32 register file, two combinational read ports, one write
// port, asynchronous clear; register 0 is hardwired to zero.
`default_nettype none

module grf_regs (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        we_i,
  input  wire logic [4:0]  waddr_i,
  input  wire logic [31:0] wdata_i,
  input  wire logic [4:0]  raddr1_i,
  input  wire logic [4:0]  raddr2_i,
  output logic      [31:0] rdata1_o,
  output logic      [31:0] rdata2_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'h0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'h0 : regs_q[raddr2_i];

endmodule

`default_nettype wire

// File: rtl/alu_dm_grf_core.sv
// alu_dm_grf_core: single-cycle MIPS execute/memory/write-back slice (GRF, extender,
// ALU, word-addressed DM, write-back mux). Define TRACE_DISPLAY_EN for commit trace.
`default_nettype none

module alu_dm_grf_core #(
  parameter int DM_WORDS = mips_pkg::DM_WORDS,
  parameter int DM_AW    = mips_pkg::DM_AW
) (
  input wire logic          clk,
  input wire logic          reset,
  alu_dm_grf_core_if.slave  bus
);
  import mips_pkg::*;

  logic [31:0]      rdata1_w;
  logic [31:0]      rdata2_w;
  logic [31:0]      ext_w;
  logic [31:0]      alu_b_w;
  logic [31:0]      alu_res_w;
  logic [31:0]      dm_rdata_w;
  logic [31:0]      wdata_w;
  logic [DM_AW-1:0] dm_idx_w;
  logic             dm_hit_w;
  logic [31:0]      dm_q [DM_WORDS];

  grf_regs u_grf (
    .clk      (clk),
    .reset    (reset),
    .we_i     (bus.grf_we),
    .waddr_i  (bus.wreg),
    .wdata_i  (wdata_w),
    .raddr1_i (bus.rs),
    .raddr2_i (bus.rt),
    .rdata1_o (rdata1_w),
    .rdata2_o (rdata2_w)
  );

  assign ext_w   = ext_imm(bus.imm16, bus.ext_zero);
  assign alu_b_w = bus.alu_src ? ext_w : rdata2_w;

  always_comb begin
    alu_res_w = 32'h0;
    case (bus.alu_op)
      ALU_ADD: alu_res_w = rdata1_w + alu_b_w;
      ALU_SUB: alu_res_w = rdata1_w - alu_b_w;
      ALU_OR:  alu_res_w = rdata1_w | alu_b_w;
      ALU_AND: alu_res_w = rdata1_w & alu_b_w;
      ALU_LUI: alu_res_w = {alu_b_w[15:0], 16'h0000};
      default: alu_res_w = 32'h0;
    endcase
  end

  // Any set bit above the index field aliases nowhere: treat as out of range.
  assign dm_idx_w   = alu_res_w[DM_AW+1:2];
  assign dm_hit_w   = (alu_res_w[31:DM_AW+2] == '0) && (int'(dm_idx_w) < DM_WORDS);
  assign dm_rdata_w = dm_hit_w ? dm_q[dm_idx_w] : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) dm_q[i] <= '0;
    end else if (bus.dm_we && dm_hit_w) begin
      dm_q[dm_idx_w] <= rdata2_w;
    end
  end

  always_comb begin
    wdata_w = 32'h0;
    case (bus.wd_sel)
      WD_ALU:  wdata_w = alu_res_w;
      WD_MEM:  wdata_w = dm_rdata_w;
      WD_LINK: wdata_w = bus.link_addr;
      default: wdata_w = 32'h0;
    endcase
  end

  assign bus.rdata1     = rdata1_w;
  assign bus.rdata2     = rdata2_w;
  assign bus.alu_result = alu_res_w;
  assign bus.equal      = (rdata1_w == alu_b_w);
  assign bus.wdata      = wdata_w;

`ifdef TRACE_DISPLAY_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (bus.grf_we && (bus.wreg != 5'd0))
        $display("@%h: $%d <= %h", bus.pc, bus.wreg, wdata_w);
      if (bus.dm_we && dm_hit_w)
        $display("@%h: *%h <= %h", bus.pc, {alu_res_w[31:2], 2'b00}, rdata2_w);
    end
  end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_dm_grf_core.sv
// tb_alu_dm_grf_core: directed scoreboard bench for the alu_dm_grf_core datapath slice.
`default_nettype none

module tb_alu_dm_grf_core;
  import mips_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  alu_dm_grf_core_if bus ();

  alu_dm_grf_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push_exp(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle();
    bus.rs = 5'd0;  bus.rt = 5'd0;  bus.wreg = 5'd0;  bus.imm16 = 16'h0;
    bus.ext_zero = 1'b0;  bus.alu_src = 1'b0;  bus.alu_op = ALU_ADD;
    bus.grf_we = 1'b0;  bus.dm_we = 1'b0;  bus.wd_sel = WD_ALU;
    bus.link_addr = 32'h0;
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
    bus.pc = bus.pc + 32'd4;
  endtask

  // Two-instruction lui/ori sequence to load an arbitrary constant.
  task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
    idle();
    bus.imm16 = v[31:16];  bus.alu_src = 1'b1;  bus.alu_op = ALU_LUI;
    bus.wreg = r;  bus.grf_we = 1'b1;
    edge_();
    bus.rs = r;  bus.imm16 = v[15:0];  bus.ext_zero = 1'b1;  bus.alu_op = ALU_OR;
    edge_();
    bus.grf_we = 1'b0;
  endtask

  task automatic read_reg(input string tag, input logic [4:0] r, input logic [31:0] v);
    bus.rs = r;
    push_exp(tag, v);
    #1;
    check(bus.rdata1);
  endtask

  initial begin
    bus.pc = 32'h0000_3000;
    idle();

    // Reset state
    bus.rs = 5'd5;  bus.rt = 5'd31;
    bus.imm16 = 16'h0010;  bus.alu_src = 1'b1;  bus.wd_sel = WD_MEM;
    #2;
    push_exp("reset_rdata1", 32'h0);     check(bus.rdata1);
    push_exp("reset_rdata2", 32'h0);     check(bus.rdata2);
    push_exp("reset_addr", 32'h10);      check(bus.alu_result);
    push_exp("reset_dm_0x10", 32'h0);    check(bus.wdata);
    @(negedge clk);
    reset = 1'b0;

    // ori / addi with zero- and sign-extension; no write-to-read bypass
    idle();
    bus.imm16 = 16'h8000;  bus.ext_zero = 1'b1;  bus.alu_src = 1'b1;
    bus.alu_op = ALU_OR;  bus.wreg = 5'd8;  bus.grf_we = 1'b1;
    push_exp("ori_wdata", 32'h0000_8000);
    #1;  check(bus.wdata);
    edge_();
    bus.grf_we = 1'b0;
    read_reg("ori_r8", 5'd8, 32'h0000_8000);
    bus.rs = 5'd0;  bus.rt = 5'd8;  bus.ext_zero = 1'b0;  bus.alu_op = ALU_ADD;
    bus.grf_we = 1'b1;
    push_exp("no_bypass_r8", 32'h0000_8000);
    #1;  check(bus.rdata2);
    edge_();
    bus.grf_we = 1'b0;
    push_exp("addi_r8_port2", 32'hFFFF_8000);
    #1;  check(bus.rdata2);

    // sub wrap, lui, unused opcodes
    set_reg(5'd2, 32'h1);
    idle();
    bus.rs = 5'd1;  bus.rt = 5'd2;  bus.alu_op = ALU_SUB;
    push_exp("sub_wrap", 32'hFFFF_FFFF);
    #1;  check(bus.alu_result);
    bus.imm16 = 16'h1234;  bus.alu_src = 1'b1;  bus.alu_op = ALU_LUI;
    push_exp("lui", 32'h1234_0000);
    #1;  check(bus.alu_result);
    bus.alu_op = 3'd5;
    push_exp("op5_zero", 32'h0);
    #1;  check(bus.alu_result);
    bus.alu_op = 3'd7;
    push_exp("op7_zero", 32'h0);
    #1;  check(bus.alu_result);

    // store / load
    set_reg(5'd3, 32'hDEAD_BEEF);
    idle();
    bus.rt = 5'd3;  bus.imm16 = 16'h0004;  bus.alu_src = 1'b1;  bus.dm_we = 1'b1;
    edge_();
    bus.dm_we = 1'b0;  bus.wd_sel = WD_MEM;  bus.wreg = 5'd4;  bus.grf_we = 1'b1;
    push_exp("load_wdata", 32'hDEAD_BEEF);
    #1;  check(bus.wdata);
    edge_();
    bus.grf_we = 1'b0;
    read_reg("load_r4", 5'd4, 32'hDEAD_BEEF);

    idle();
    bus.rs = 5'd3;  bus.imm16 = 16'hFFFF;  bus.ext_zero = 1'b1;  bus.alu_src = 1'b1;
    bus.alu_op = ALU_AND;
    push_exp("andi_zext", 32'h0000_BEEF);
    #1;  check(bus.alu_result);
    bus.ext_zero = 1'b0;
    push_exp("and_sext", 32'hDEAD_BEEF);
    #1;  check(bus.alu_result);

    // out-of-range store dropped; last in-range word works
    idle();
    bus.rt = 5'd3;  bus.imm16 = 16'h3000;  bus.ext_zero = 1'b1;  bus.alu_src = 1'b1;
    bus.dm_we = 1'b1;
    edge_();
    bus.dm_we = 1'b0;  bus.wd_sel = WD_MEM;
    push_exp("dm_0x3000", 32'h0);
    #1;  check(bus.wdata);
    bus.imm16 = 16'h2FFC;  bus.dm_we = 1'b1;
    edge_();
    bus.dm_we = 1'b0;
    push_exp("dm_0x2ffc", 32'hDEAD_BEEF);
    #1;  check(bus.wdata);

    // high address bits set: reads 0, store dropped even though index aliases word 1
    idle();
    bus.imm16 = 16'h8004;  bus.alu_src = 1'b1;  bus.wd_sel = WD_MEM;
    push_exp("dm_hi_alias_rd", 32'h0);
    #1;  check(bus.wdata);
    bus.dm_we = 1'b1;
    edge_();
    bus.dm_we = 1'b0;  bus.imm16 = 16'h0004;
    push_exp("dm_hi_alias_wr", 32'hDEAD_BEEF);
    #1;  check(bus.wdata);

    // $0 discards writes
    idle();
    bus.imm16 = 16'h0055;  bus.alu_src = 1'b1;  bus.grf_we = 1'b1;
    push_exp("r0_wdata", 32'h55);
    #1;  check(bus.wdata);
    edge_();
    bus.grf_we = 1'b0;
    read_reg("r0_zero", 5'd0, 32'h0);

    // equal flag, independent of alu_op
    set_reg(5'd5, 32'd7);
    set_reg(5'd6, 32'd7);
    idle();
    bus.rs = 5'd5;  bus.rt = 5'd6;
    push_exp("equal_7_7", 32'h1);
    #1;  check({31'h0, bus.equal});
    set_reg(5'd6, 32'd8);
    idle();
    bus.rs = 5'd5;  bus.rt = 5'd6;
    push_exp("equal_7_8", 32'h0);
    #1;  check({31'h0, bus.equal});
    bus.alu_src = 1'b1;  bus.imm16 = 16'd7;  bus.alu_op = ALU_OR;
    push_exp("equal_imm", 32'h1);
    #1;  check({31'h0, bus.equal});
    bus.wd_sel = 2'd3;
    push_exp("wd_sel3", 32'h0);
    #1;  check(bus.wdata);

    // asynchronous reset mid-cycle blocks pending writes
    idle();
    bus.rs = 5'd3;  bus.rt = 5'd3;  bus.imm16 = 16'h2FFC;  bus.alu_src = 1'b1;
    bus.wreg = 5'd9;  bus.grf_we = 1'b1;  bus.dm_we = 1'b1;
    push_exp("pre_reset_r3", 32'hDEAD_BEEF);
    #1;  check(bus.rdata1);
    #2;
    reset = 1'b1;
    #1;
    push_exp("async_clear_r3", 32'h0);
    check(bus.rdata1);
    bus.rs = 5'd0;  bus.imm16 = 16'h0004;  bus.wd_sel = WD_MEM;
    push_exp("async_clear_dm1", 32'h0);
    #1;  check(bus.wdata);
    bus.rs = 5'd3;  bus.wd_sel = WD_ALU;
    edge_();
    reset = 1'b0;
    bus.grf_we = 1'b0;  bus.dm_we = 1'b0;
    read_reg("no_write_r9", 5'd9, 32'h0);
    bus.rs = 5'd0;  bus.imm16 = 16'h2FFC;  bus.wd_sel = WD_MEM;
    push_exp("no_write_dm", 32'h0);
    #1;  check(bus.wdata);

    // jal link write-back
    idle();
    bus.wd_sel = WD_LINK;  bus.link_addr = 32'h0000_3008;  bus.wreg = 5'd31;
    bus.grf_we = 1'b1;
    push_exp("jal_wdata", 32'h0000_3008);
    #1;  check(bus.wdata);
    edge_();
    bus.grf_we = 1'b0;
    read_reg("jal_r31", 5'd31, 32'h0000_3008);

    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
